// File: rtl/dram_pkg.sv
// Shared types for the TMS4464 pin-level responder: FSM states, violation causes
// and a saturating 8-bit increment used by the RAS interval counter.
package dram_pkg;

   typedef enum logic [1:0] {PRECHARGE, ROW_OPEN, COL_ACTIVE, CBR} state_t;

   typedef enum logic [2:0] {NONE, TRAS, TRP, NOINIT, LATEWR, CBRSEQ} viol_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/dram_array.sv
// Single-port nybble store with synchronous write and registered read; the read
// register resets to zero so the responder's data pins start clean.
module dram_array #(
   parameter int AW = 12,
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;

   always_ff @(posedge clk)
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[addr];

endmodule

// File: rtl/dram_responder.sv
// TMS4464 pin-level responder: row/col latching, early write, (page) read, CBR refresh,
// protocol checks. Define DRAM_RESPONDER_DECAY_EN to model per-row charge decay.
module dram_responder
   import dram_pkg::*;
#(
   parameter int ROW_BITS    = 4,
   parameter int COL_BITS    = 8,
   parameter int TRAS_MIN    = 4,
   parameter int TRP_MIN     = 4,
   parameter int INIT_CYCLES = 8,
   parameter int RETENTION   = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ram_addr,
   input  logic       ram_ras_,
   input  logic       ram_cas_,
   input  logic       ram_we_,
   input  logic       ram_oe_,
   input  logic [3:0] dq_in,
   output logic [3:0] dq_out,
   output logic       dq_oe,
   output logic       init_done,
   output logic       viol,
   output logic [2:0] viol_code,
   output logic       decay_err
);

   localparam int AW   = ROW_BITS + COL_BITS;
   localparam int ROWS = 1 << ROW_BITS;
   localparam int ICW  = $clog2(INIT_CYCLES + 1);
   localparam logic [7:0] TRAS_L = 8'(TRAS_MIN);
   localparam logic [7:0] TRP_L  = 8'(TRP_MIN);

   logic                p_ras, p_cas, p_we, p_oe, pp_ras, pp_cas, pp_we;
   logic [7:0]          p_addr;
   logic [3:0]          p_dq, rd_data;
   state_t              state;
   viol_t               vcode, vnext;
   logic [ROW_BITS-1:0] row, refresh_row;
   logic [7:0]          tcnt;
   logic [ICW-1:0]      init_cnt;
   logic                rd_vld;

   wire ras_fall = pp_ras & ~p_ras;
   wire ras_rise = ~pp_ras & p_ras;
   wire cas_fall = pp_cas & ~p_cas;
   wire cas_rise = ~pp_cas & p_cas;
   wire we_fall  = pp_we & ~p_we;
   wire open     = (state != PRECHARGE);
   wire row_close = ras_rise && (state == ROW_OPEN || state == COL_ACTIVE);
   wire access   = (state == ROW_OPEN) && cas_fall && !ras_rise;
   wire wr       = access & ~p_we;
   wire rd       = access & p_we;
   // CAS must already have been low before this sample for the fall to count as CBR
   wire cbr_start = (state == PRECHARGE) && ras_fall && !p_cas && !pp_cas;
   wire row_start = (state == PRECHARGE) && ras_fall && !cbr_start;

   assign init_done = (init_cnt == ICW'(INIT_CYCLES));
   assign viol_code = vcode;
   assign dq_oe     = (state == COL_ACTIVE) && rd_vld && !p_oe;

   always_comb begin
      vnext = NONE;
      if (ras_rise && open && tcnt < TRAS_L)              vnext = TRAS;
      else if (ras_fall && !open && tcnt < TRP_L)         vnext = TRP;
      else if (access && !init_done)                      vnext = NOINIT;
      else if (we_fall && state == COL_ACTIVE)            vnext = LATEWR;
      else if (state == CBR && cas_rise && !ras_rise)     vnext = CBRSEQ;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         {p_ras, p_cas, p_we, p_oe} <= 4'hF;
         {pp_ras, pp_cas, pp_we}    <= 3'h7;
         p_addr      <= '0;
         p_dq        <= '0;
         state       <= PRECHARGE;
         row         <= '0;
         refresh_row <= '0;
         tcnt        <= 8'hFF;
         init_cnt    <= '0;
         rd_vld      <= 1'b0;
         viol        <= 1'b0;
         vcode       <= NONE;
      end else begin
         {p_ras, p_cas, p_we, p_oe} <= {ram_ras_, ram_cas_, ram_we_, ram_oe_};
         {pp_ras, pp_cas, pp_we}    <= {p_ras, p_cas, p_we};
         p_addr <= ram_addr;
         p_dq   <= dq_in;
         tcnt   <= (ras_fall || ras_rise) ? 8'd1 : sat_inc8(tcnt);
         if (!viol && vnext != NONE) begin
            viol  <= 1'b1;
            vcode <= vnext;
         end
         if (ras_rise) begin
            state  <= PRECHARGE;
            rd_vld <= 1'b0;
            if (open && !init_done) init_cnt <= init_cnt + ICW'(1);
         end else begin
            case (state)
               PRECHARGE:
                  if (cbr_start) begin
                     state       <= CBR;
                     refresh_row <= refresh_row + ROW_BITS'(1);
                  end else if (row_start) begin
                     state <= ROW_OPEN;
                     row   <= p_addr[ROW_BITS-1:0];
                  end
               ROW_OPEN:
                  if (cas_fall) begin
                     state  <= COL_ACTIVE;
                     rd_vld <= p_we;
                  end
               COL_ACTIVE:
                  if (cas_rise) begin
                     state  <= ROW_OPEN;
                     rd_vld <= 1'b0;
                  end
               default: ;
            endcase
         end
      end
   end

   // rst_n gates the write so a cycle abandoned by reset never commits
   dram_array #(.AW(AW), .DW(4)) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr & rst_n),
      .re    (rd),
      .addr  ({row, p_addr[COL_BITS-1:0]}),
      .wdata (p_dq),
      .rdata (rd_data)
   );

`ifdef DRAM_RESPONDER_DECAY_EN
   localparam int AGE_W = $clog2(RETENTION) + 1;
   logic [AGE_W-1:0] age [ROWS];
   logic             decayed, derr;

   always_ff @(posedge clk) begin
      for (int r = 0; r < ROWS; r++) begin
         if (!rst_n)
            age[r] <= '0;
         else if ((row_close && row == ROW_BITS'(r)) || (cbr_start && refresh_row == ROW_BITS'(r)))
            age[r] <= '0;
         else if (age[r] != '1)
            age[r] <= age[r] + AGE_W'(1);
      end
   end

   // a decayed read returns inverted data, aligned with the array's read register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         decayed <= 1'b0;
         derr    <= 1'b0;
      end else if (rd) begin
         decayed <= (age[row] >= AGE_W'(RETENTION));
         if (age[row] >= AGE_W'(RETENTION)) derr <= 1'b1;
      end
   end

   assign dq_out    = rd_data ^ {4{decayed}};
   assign decay_err = derr;
`else
   assign dq_out    = rd_data;
   assign decay_err = 1'b0;
`endif

endmodule
